// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver with 2-FF input sync, oversampling baud counter and FWFT receive FIFO
module uart_rx_fifo #(
  parameter int CPU_CLOCK_FREQ = 250_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       serial_rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overrun_o,
  input  logic       clr_err_i
);
  localparam int CLKS_PER_BIT = CPU_CLOCK_FREQ / BAUD_RATE;
  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
  state_t state, state_n;
  logic sync1, rx_s;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] shift;
  logic push_q, frame_err, overrun;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;
  logic stop_hit, pop, full, acc;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  state_n = rx_s ? IDLE : START;
      START: state_n = (cnt == HALF_M1) ? (rx_s ? IDLE : DATA) : START;
      DATA:  state_n = (cnt == LAST && bit_idx == 3'd7) ? STOP : DATA;
      STOP:  state_n = (cnt == LAST) ? (rx_s ? IDLE : BRK) : STOP;
      BRK:   state_n = rx_s ? IDLE : BRK;
      default: state_n = IDLE;
    endcase
  end
  assign stop_hit = (state == STOP) && (cnt == LAST);
  assign valid_o = (count != '0);
  assign data_o = mem[rd_ptr];
  assign pop = valid_o && ready_i;
  assign full = (count == DEPTH);
  assign acc = push_q && (!full || pop);
  assign frame_err_o = frame_err;
  assign overrun_o = overrun;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1 <= 1'b1;
      rx_s <= 1'b1;
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      shift <= '0;
      push_q <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync1 <= serial_rx_i;
      rx_s <= sync1;
      state <= state_n;
      cnt <= (state_n != state || cnt == LAST) ? '0 : cnt + CW'(1);
      if (state != DATA) bit_idx <= '0;
      else if (cnt == LAST) begin
        shift[bit_idx] <= rx_s;
        bit_idx <= bit_idx + 3'd1;
      end
      push_q <= stop_hit && rx_s;
      frame_err <= stop_hit && !rx_s;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      overrun <= 1'b0;
    end else begin
      if (acc) begin
        mem[wr_ptr] <= shift;
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= (acc && !pop) ? count + (AW+1)'(1) : (pop && !acc) ? count - (AW+1)'(1) : count;
      overrun <= (push_q && full && !pop) ? 1'b1 : clr_err_i ? 1'b0 : overrun;
    end
  end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Standalone UART receiver front end for the serial console path. Consumes the raw SERIALRX pad line and produces bytes toward the core's UART data path.
- Oversamples 8N1 frames with a baud counter derived from the CPU clock. Buffers received bytes in a small FIFO and presents them over a valid/ready handshake.
- Flags framing errors and overruns.

Parameters:
- CPU_CLOCK_FREQ, 250_000_000, core clock frequency in Hz.
- BAUD_RATE, 115200, serial bit rate.
- FIFO_DEPTH, 4, receive FIFO entries; power of two, minimum 2.
- Derived: CLKS_PER_BIT = CPU_CLOCK_FREQ / BAUD_RATE (integer divide; 2170 at defaults). HALF_BIT = CLKS_PER_BIT / 2.

Ports:
- clk_i  input  1  core clock.
- rst_i  input  1  reset, asynchronous assert, active-high.
- serial_rx_i  input  1  raw asynchronous serial line; idles high.
- data_o  output  8  byte at FIFO head; valid only when valid_o=1.
- valid_o  output  1  FIFO not empty.
- ready_i  input  1  consumer accepts data_o this cycle.
- frame_err_o  output  1  one-cycle pulse: stop bit sampled low.
- overrun_o  output  1  sticky: byte dropped because FIFO full.
- clr_err_i  input  1  synchronous clear of overrun_o.

Interface: one clock (clk_i); reset rst_i is asynchronous and active-high.

Behaviour:
- Reset values:
  - data_o=0, valid_o=0, frame_err_o=0, overrun_o=0.
  - FIFO empty, read/write pointers 0, state IDLE.
  - Both synchronizer flops =1, so reset does not read as a start bit.
- Input sync: 2-FF synchronizer on serial_rx_i; rx_s is the second flop. All decisions use rx_s.
- Baud counter: counts 0..CLKS_PER_BIT-1. It resets to 0 on every state entry.
- IDLE: rx_s=0 -> START.
- START:
  - At counter=HALF_BIT-1, sample rx_s.
  - rx_s=0 -> DATA, bit index 0.
  - rx_s=1 -> false start, back to IDLE, nothing pushed.
- DATA:
  - At counter=CLKS_PER_BIT-1, sample rx_s into shift[bit index], LSB first, then increment the index.
  - After index 7 is sampled -> STOP.
- STOP: at counter=CLKS_PER_BIT-1, sample rx_s.
  - rx_s=1: push the byte if the FIFO is not full, then -> IDLE. If full, drop the byte, set overrun_o=1, then -> IDLE.
  - rx_s=0: pulse frame_err_o for 1 cycle, discard the byte, -> BREAK.
- BREAK: wait until rx_s=1, then -> IDLE. A held-low line produces exactly one frame_err pulse.
- Timing:
  - Stop-bit sample occurs HALF_BIT + 9*CLKS_PER_BIT cycles after START entry.
  - The push is registered on that cycle, so valid_o rises the next clock edge.
- FIFO:
  - First-word-fall-through: data_o = mem[rd_ptr], valid_o = (count!=0).
  - Pop when valid_o && ready_i.
  - Pointers wrap modulo FIFO_DEPTH. count is $clog2(FIFO_DEPTH)+1 bits.
  - ready_i while empty has no effect.
- Simultaneous events:
  - Push and pop in the same cycle: both take effect, count unchanged.
  - This includes the full case: the pop frees a slot, the push is accepted, and no overrun is flagged.
- Overrun clear: overrun_o holds until clr_err_i=1. If a new overrun and clr_err_i coincide, set wins.
- Bytes already in the FIFO are unaffected by a framing error or overrun.
- Reset mid-frame: immediate return to the reset state. The partial byte and FIFO contents are lost.

Test Plan (simulation parameters CPU_CLOCK_FREQ=1_600_000, BAUD_RATE=100_000, so CLKS_PER_BIT=16, HALF_BIT=8; FIFO_DEPTH=4):
- Single frame 0xA5, ready_i=0:
  - valid_o rises exactly 8+144+1 cycles after START entry, data_o=0xA5.
  - After one ready_i cycle, valid_o=0.
- Glitch: serial_rx_i low for 4 clocks, then high -> state returns to IDLE, valid_o stays 0, no frame_err pulse.
- Framing error: frame 0x3C with stop bit low, line held low 50 more bits -> exactly one frame_err_o pulse, FIFO empty. Next valid frame 0x11 received correctly.
- Overrun: send 0x01..0x05 with ready_i=0:
  - First four are stored, fifth is dropped, overrun_o=1.
  - Draining yields 0x01..0x04.
  - clr_err_i pulse -> overrun_o=0.
- Full plus pop: FIFO holds 4 bytes, with ready_i=1 on the exact push cycle of 0x77 -> no overrun, count stays 4, 0x77 is read last.
- Async reset asserted mid-DATA of frame 0xFF with 2 bytes queued -> all outputs 0 immediately. After release, frame 0x5A is received correctly.
